send_buffer: RTL

SEND_BUFFER -- requirements
Module: send_buffer

---
 rtl/send_buffer.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/send_buffer.sv
// send_buffer: frames ARP or IP payload streams into Ethernet frames.
// It prepends the destination MAC, the source MAC and the ethertype, passes
// the granted payload through with zero latency, and pads short frames with
// zeros up to MIN_FRAME bytes.
module send_buffer #(
    parameter int unsigned MIN_FRAME = 60
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [47:0] mac_addr,
    input  logic [7:0]  arp_axis_tdata_in,
    input  logic        arp_axis_tvalid_in,
    input  logic        arp_axis_tlast_in,
    output logic        arp_axis_tready_o,
    input  logic [47:0] arp_dst_mac_in,
    input  logic [7:0]  ip_axis_tdata_in,
    input  logic        ip_axis_tvalid_in,
    input  logic        ip_axis_tlast_in,
    output logic        ip_axis_tready_o,
    input  logic [47:0] ip_dst_mac_in,
    output logic [7:0]  axis_tdata_out,
    output logic        axis_tvalid_out,
    output logic        axis_tlast_out,
    input  logic        axis_tready_in
);

    localparam int unsigned HDR_LEN = 14;
    localparam int unsigned CNT_W   = 11;

    localparam logic [CNT_W-1:0] DES_LAST  = CNT_W'(5);
    localparam logic [CNT_W-1:0] SRC_LAST  = CNT_W'(11);
    localparam logic [CNT_W-1:0] PRTC_LAST = CNT_W'(HDR_LEN - 1);
    localparam logic [CNT_W-1:0] MIN_CNT   = CNT_W'(MIN_FRAME);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    localparam logic [15:0] ETH_ARP = 16'h0806;
    localparam logic [15:0] ETH_IP  = 16'h0800;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DES_MAC = 3'd1,
        SRC_MAC = 3'd2,
        PRTC    = 3'd3,
        PAYLOAD = 3'd4,
        PAD     = 3'd5
    } state_t;

    state_t           state;
    logic [47:0]      dst_mac;
    logic [47:0]      src_mac;
    logic [15:0]      ethertype;
    logic             grant_arp;
    logic [CNT_W-1:0] count;

    logic [CNT_W-1:0] count_inc;
    logic             frame_full;
    logic             src_tlast;
    logic             fire;

    // Saturating next byte count and the "minimum length reached" flag
    always_comb begin
        count_inc  = (count == CNT_MAX) ? count : count + CNT_W'(1);
        frame_full = (count_inc >= MIN_CNT);
        src_tlast  = grant_arp ? arp_axis_tlast_in : ip_axis_tlast_in;
        fire       = axis_tvalid_out && axis_tready_in;
    end

    // Output mux: header bytes from shift registers, payload passed straight through
    always_comb begin
        axis_tdata_out    = 8'h00;
        axis_tvalid_out   = 1'b0;
        axis_tlast_out    = 1'b0;
        arp_axis_tready_o = 1'b0;
        ip_axis_tready_o  = 1'b0;
        case (state)
            DES_MAC: begin
                axis_tdata_out  = dst_mac[47:40];
                axis_tvalid_out = 1'b1;
            end
            SRC_MAC: begin
                axis_tdata_out  = src_mac[47:40];
                axis_tvalid_out = 1'b1;
            end
            PRTC: begin
                axis_tdata_out  = ethertype[15:8];
                axis_tvalid_out = 1'b1;
            end
            PAYLOAD: begin
                if (grant_arp) begin
                    axis_tdata_out    = arp_axis_tdata_in;
                    axis_tvalid_out   = arp_axis_tvalid_in;
                    axis_tlast_out    = arp_axis_tvalid_in && arp_axis_tlast_in && frame_full;
                    arp_axis_tready_o = axis_tready_in;
                end else begin
                    axis_tdata_out    = ip_axis_tdata_in;
                    axis_tvalid_out   = ip_axis_tvalid_in;
                    axis_tlast_out    = ip_axis_tvalid_in && ip_axis_tlast_in && frame_full;
                    ip_axis_tready_o  = axis_tready_in;
                end
            end
            PAD: begin
                axis_tvalid_out = 1'b1;
                axis_tlast_out  = frame_full;
            end
            default: begin
                axis_tdata_out  = 8'h00;
            end
        endcase
    end

    // Frame sequencer: arbitration, header shifting, byte counting
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            dst_mac   <= '0;
            src_mac   <= '0;
            ethertype <= '0;
            grant_arp <= 1'b0;
            count     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    count <= '0;
                    if (arp_axis_tvalid_in) begin
                        dst_mac   <= arp_dst_mac_in;
                        src_mac   <= mac_addr;
                        ethertype <= ETH_ARP;
                        grant_arp <= 1'b1;
                        state     <= DES_MAC;
                    end else if (ip_axis_tvalid_in) begin
                        dst_mac   <= ip_dst_mac_in;
                        src_mac   <= mac_addr;
                        ethertype <= ETH_IP;
                        grant_arp <= 1'b0;
                        state     <= DES_MAC;
                    end
                end
                DES_MAC: begin
                    if (fire) begin
                        count   <= count_inc;
                        dst_mac <= {dst_mac[39:0], 8'h00};
                        if (count == DES_LAST) state <= SRC_MAC;
                    end
                end
                SRC_MAC: begin
                    if (fire) begin
                        count   <= count_inc;
                        src_mac <= {src_mac[39:0], 8'h00};
                        if (count == SRC_LAST) state <= PRTC;
                    end
                end
                PRTC: begin
                    if (fire) begin
                        count     <= count_inc;
                        ethertype <= {ethertype[7:0], 8'h00};
                        if (count == PRTC_LAST) state <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (fire) begin
                        count <= count_inc;
                        if (src_tlast) state <= frame_full ? IDLE : PAD;
                    end
                end
                PAD: begin
                    if (fire) begin
                        count <= count_inc;
                        if (frame_full) state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
